// File: rtl/ysyx_22040729_div_seq_if.sv
// Request/response channel between the execute stage (master) and the
// sequential divider (slave).
interface ysyx_22040729_div_seq_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  div_signed;
    logic                  div_word;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;

    modport master (
        output in_valid, dividend, divisor, div_signed, div_word, flush, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, dividend, divisor, div_signed, div_word, flush, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/ysyx_22040729_div_seq.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve on accept.
// Optional macro YSYX_22040729_DIV_EARLY_OUT_EN: finish in one cycle when
// |dividend| < |divisor|.
module ysyx_22040729_div_seq #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input logic                    clk_i,
    input logic                    rst_i,
    ysyx_22040729_div_seq_if.slave bus_io
);
    localparam int unsigned HalfW = DATA_WIDTH / 2;
    localparam int unsigned CntW  = $clog2(DATA_WIDTH);

    localparam logic [DATA_WIDTH-1:0] MinNegD  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MinNegW  = {{HalfW{1'b0}}, 1'b1, {(HalfW-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] AllOnesW = {{HalfW{1'b0}}, {HalfW{1'b1}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  neg_q_q, neg_q_d;
    logic                  neg_r_q, neg_r_d;
    logic                  word_q, word_d;
    logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0] remainder_q, remainder_d;

    function automatic logic [DATA_WIDTH-1:0] sext_word(input logic [DATA_WIDTH-1:0] v);
        return {{HalfW{v[HalfW-1]}}, v[HalfW-1:0]};
    endfunction

    logic accept;

    // Operand decode on the request inputs
    logic [DATA_WIDTH-1:0] a_low, b_low, a_ext, b_ext, a_neg, b_neg, a_mag, b_mag;
    logic                  sign_a, sign_b, div_zero, overflow, early, special;
    logic [DATA_WIDTH-1:0] spec_quo, spec_rem;

    // Operand decode: magnitudes, signs and special-case detection
    always_comb begin
        a_low  = bus_io.div_word ? {{HalfW{1'b0}}, bus_io.dividend[HalfW-1:0]} : bus_io.dividend;
        b_low  = bus_io.div_word ? {{HalfW{1'b0}}, bus_io.divisor[HalfW-1:0]} : bus_io.divisor;
        a_ext  = bus_io.div_word ? sext_word(bus_io.dividend) : bus_io.dividend;
        b_ext  = bus_io.div_word ? sext_word(bus_io.divisor) : bus_io.divisor;
        sign_a = bus_io.div_signed & a_ext[DATA_WIDTH-1];
        sign_b = bus_io.div_signed & b_ext[DATA_WIDTH-1];
        a_neg  = sign_a ? -a_ext : a_ext;
        b_neg  = sign_b ? -b_ext : b_ext;
        // Magnitudes are confined to the active width
        a_mag  = bus_io.div_word ? {{HalfW{1'b0}}, a_neg[HalfW-1:0]} : a_neg;
        b_mag  = bus_io.div_word ? {{HalfW{1'b0}}, b_neg[HalfW-1:0]} : b_neg;

        div_zero = (b_low == '0);
        overflow = bus_io.div_signed
                 & (a_low == (bus_io.div_word ? MinNegW : MinNegD))
                 & (b_low == (bus_io.div_word ? AllOnesW : '1));
`ifdef YSYX_22040729_DIV_EARLY_OUT_EN
        early = (a_mag < b_mag);
`else
        early = 1'b0;
`endif
        special = div_zero | overflow | early;

        spec_quo = '0;
        spec_rem = a_ext;
        if (div_zero) begin
            spec_quo = '1;
            spec_rem = a_ext;
        end else if (overflow) begin
            spec_quo = a_ext;
            spec_rem = '0;
        end
    end

    // One restoring step on the current partial remainder
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH-1:0] rem_diff, rem_iter, quo_iter, q_signed, r_signed;
    logic                  no_borrow;

    // Trial subtraction and final sign correction
    always_comb begin
        rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
        no_borrow = (rem_shift >= {1'b0, dvs_q});
        // Only used when no borrow, so the true difference fits DATA_WIDTH bits
        rem_diff  = rem_shift[DATA_WIDTH-1:0] - dvs_q;
        rem_iter  = no_borrow ? rem_diff : rem_shift[DATA_WIDTH-1:0];
        quo_iter  = {quo_q[DATA_WIDTH-2:0], no_borrow};
        q_signed  = neg_q_q ? -quo_iter : quo_iter;
        r_signed  = neg_r_q ? -rem_iter : rem_iter;
    end

    assign accept = bus_io.in_valid & (state_q == StIdle) & ~bus_io.flush;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush beats both accept and the response handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = special ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (bus_io.flush) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus_io.flush || bus_io.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus_io.in_ready  = (state_q == StIdle);
        bus_io.out_valid = (state_q == StDone);
        bus_io.quotient  = quotient_q;
        bus_io.remainder = remainder_q;
    end

    // Datapath next state: capture on accept, iterate in CALC
    always_comb begin
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        word_d      = word_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        if (state_q == StIdle && accept) begin
            rem_d   = '0;
            // Word operands sit in the upper half so the MSB feeds the shift
            quo_d   = bus_io.div_word ? {a_mag[HalfW-1:0], {HalfW{1'b0}}} : a_mag;
            dvs_d   = b_mag;
            cnt_d   = bus_io.div_word ? CntW'(HalfW - 1) : CntW'(DATA_WIDTH - 1);
            neg_q_d = sign_a ^ sign_b;
            neg_r_d = sign_a;
            word_d  = bus_io.div_word;
            if (special) begin
                quotient_d  = spec_quo;
                remainder_d = spec_rem;
            end
        end else if (state_q == StCalc && !bus_io.flush) begin
            rem_d = rem_iter;
            quo_d = quo_iter;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                quotient_d  = word_q ? sext_word(q_signed) : q_signed;
                remainder_d = word_q ? sext_word(r_signed) : r_signed;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            word_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            word_q      <= word_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22040729_div_seq.sv
// Directed bench for the sequential divider.
module tb_ysyx_22040729_div_seq;
    localparam int unsigned DW = 64;

`ifdef YSYX_22040729_DIV_EARLY_OUT_EN
    localparam int EarlyLat = 1;
`else
    localparam int EarlyLat = 65;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    ysyx_22040729_div_seq_if #(.DATA_WIDTH(DW)) bus ();

    ysyx_22040729_div_seq #(.DATA_WIDTH(DW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request and let it be accepted on the next edge; returns after that edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input logic w);
        @(negedge clk);
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_signed = s;
        bus.div_word   = w;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        // Operands must be ignored after the accept cycle
        bus.dividend   = {$urandom, $urandom};
        bus.divisor    = {$urandom, $urandom};
        bus.div_signed = ~s;
        bus.div_word   = ~w;
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic w, input logic [63:0] eq,
                          input logic [63:0] er, input int elat, input logic ack);
        int lat;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        issue(a, b, s, w);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(elat));
        check_eq({tag, "_quo"}, bus.quotient, eq);
        check_eq({tag, "_rem"}, bus.remainder, er);
        if (ack) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            check_eq({tag, "_ack_valid"}, 64'(bus.out_valid), 64'd0);
            check_eq({tag, "_ack_ready"}, 64'(bus.in_ready), 64'd1);
        end
    endtask

    initial begin
        logic seen;
        bus.in_valid   = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        bus.div_signed = 1'b0;
        bus.div_word   = 1'b0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_quo", bus.quotient, 64'd0);
        check_eq("rst_rem", bus.remainder, 64'd0);

        run_op("div_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b1);
        run_op("divu_by0", 64'd100, 64'd0, 1'b0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 1, 1'b1);
        run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
               64'hFFFF_FFFF_8000_0000, 64'd0, 1, 1'b1);
        run_op("remuw", 64'h1234_5678_FFFF_FFFF, 64'h10, 1'b0, 1'b1,
               64'h0000_0000_0FFF_FFFF, 64'h0000_0000_0000_000F, 33, 1'b1);
        run_op("divw_m20_3", 64'hDEAD_BEEF_FFFF_FFEC, 64'h0000_0001_0000_0003, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b1);
        run_op("rem_7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65, 1'b1);
        run_op("div_m100_m7", 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0,
               64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b1);
        run_op("divuw_by0", 64'h0000_0001_8000_0000, 64'hABCD_0000_0000_0000, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1'b1);
        run_op("divu_small", 64'd3, 64'd10, 1'b0, 1'b0, 64'd0, 64'd3, EarlyLat, 1'b1);

        // Response held off: results and handshake signals stay put
        run_op("hold", 64'd1000, 64'd7, 1'b0, 1'b0, 64'd142, 64'd6, 65, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
            check_eq("hold_ready", 64'(bus.in_ready), 64'd0);
            check_eq("hold_quo", bus.quotient, 64'd142);
            check_eq("hold_rem", bus.remainder, 64'd6);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_eq("hold_rel_ready", 64'(bus.in_ready), 64'd1);

        // Flush while idle wins over a same-cycle request
        @(negedge clk);
        bus.dividend  = 64'd9;
        bus.divisor   = 64'd0;
        bus.in_valid  = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        check_eq("idle_flush_ready", 64'(bus.in_ready), 64'd1);
        check_eq("idle_flush_valid", 64'(bus.out_valid), 64'd0);

        // Flush mid-calculation
        issue(64'd50, 64'd7, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check_eq("flush_valid", 64'(bus.out_valid), 64'd0);
        check_eq("flush_ready", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check_eq("flush_no_resp", 64'(seen), 64'd0);
        run_op("after_flush", 64'd10, 64'd3, 1'b0, 1'b0, 64'd3, 64'd1, 65, 1'b1);

        // Reset mid-calculation clears everything, including the last result
        issue(64'd50, 64'd7, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.flush = 1'b0;
        check_eq("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("mid_rst_quo", bus.quotient, 64'd0);
        check_eq("mid_rst_rem", bus.remainder, 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check_eq("rst_no_resp", 64'(seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
